// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch unit. Owns the program counter, drives the
//               combinational instruction ROM, prefetches sequential words
//               into a small FIFO and hands them to decode over a
//               valid/ready handshake. Redirects flush the FIFO and reload
//               the PC.
// Optional    : IF_HALT_DETECT_EN - stop fetching after a SYSCALL word
//               (32'h0000_000C) has been enqueued; leave via reset/redirect.
// Ports       : clk            rising-edge clock
//               rst_n          synchronous active-low reset
//               rom_addr       ROM word address (fetch_pc[ADDR_W+1:2])
//               rom_data_in    ROM read data, combinational from rom_addr
//               redirect_valid branch/jump taken this cycle
//               redirect_pc    redirect target byte address
//               inst_valid     FIFO head valid to decode
//               inst_ready     decode accepts head
//               inst_data      head instruction word (0 when not valid)
//               inst_pc        head instruction byte address (0 when not valid)
//               fetch_pc       current fetch byte address
//               halted         fetch stopped on SYSCALL (0 without the macro)
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data_in,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [31:0]       inst_pc,
  output logic [31:0]       fetch_pc,
  output logic              halted
);

  localparam int unsigned      PTR_W      = $clog2(DEPTH);
  localparam int unsigned      CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic             push;
  logic             pop;

  // Only the word-aligned part of the redirect target is kept.
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];

  assign rom_addr   = fetch_pc[ADDR_W+1:2];

  // A redirect squashes the head in the same cycle so decode never consumes
  // a wrong-path instruction while the flush is in flight.
  assign inst_valid = (count != '0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;

  // A full FIFO can still accept a word when the head leaves this cycle,
  // which keeps throughput at one per cycle with ready held high.
  assign push       = !redirect_valid && (state == RUN) &&
                      ((count < FULL_COUNT) || pop);

  assign inst_data  = inst_valid ? data_mem[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;

`ifdef IF_HALT_DETECT_EN
  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // FIFO storage: no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= rom_data_in;
    end
  end

  // Control: PC, pointers, occupancy and fetch state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= RUN;
`ifdef IF_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= RUN;
`ifdef IF_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        fetch_pc <= fetch_pc + 32'd4;
`ifdef IF_HALT_DETECT_EN
        // The SYSCALL itself is enqueued; only later fetches are stopped.
        if (rom_data_in == SYSCALL_WORD) begin
          state    <= HALT;
          halted_q <= 1'b1;
        end
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. A queue-based model of
//               the fetch/FIFO behaviour predicts every output each cycle;
//               directed scenarios are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data_in;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [31:0]       inst_pc;
  logic [31:0]       fetch_pc;
  logic              halted;
  logic              syscall_en;

  always #5 clk = ~clk;

  // ROM image: word n = 32'h1000_0000 + n, optionally a SYSCALL at word 2.
  assign rom_data_in = (syscall_en && rom_addr == 10'd2) ? 32'h0000_000C
                                                         : 32'h1000_0000 + {22'd0, rom_addr};

  if_fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr      (rom_addr),
    .rom_data_in   (rom_data_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .fetch_pc      (fetch_pc),
    .halted        (halted)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic logic [31:0] model_rom(input logic [31:0] pc);
    int unsigned word;
    word = (pc / 4) % (2 ** ADDR_W);   // ROM aliases every 4 KiB
    if (syscall_en && word == 2) return 32'h0000_000C;
    return 32'h1000_0000 + word;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (q.size() != 0) && !redirect_valid;
    check("inst_valid", {31'd0, inst_valid}, {31'd0, v});
    check("inst_pc",    inst_pc,   v ? q[0].pc   : 32'h0);
    check("inst_data",  inst_data, v ? q[0].data : 32'h0);
    check("fetch_pc",   fetch_pc,  m_pc);
    check("rom_addr",   {22'd0, rom_addr}, (m_pc / 4) % (2 ** ADDR_W));
    check("halted",     {31'd0, halted}, {31'd0, m_halt});
  endtask

  // Advance the model across one rising edge using the inputs applied
  // during the preceding cycle.
  task automatic model_edge();
    bit          v;
    bit          popped;
    int          sz;
    logic [31:0] d;
    if (!rst_n) begin
      q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else if (redirect_valid) begin
      q.delete();
      m_pc   = redirect_pc & 32'hFFFF_FFFC;
      m_halt = 1'b0;
    end else begin
      v      = (q.size() != 0);
      popped = v && inst_ready;
      sz     = q.size();
      if (popped) void'(q.pop_front());
      if (!m_halt && (sz < DEPTH || popped)) begin
        d = model_rom(m_pc);
        q.push_back('{pc: m_pc, data: d});
        m_pc = m_pc + 32'd4;
        if (HALT_EN && d == 32'h0000_000C) m_halt = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset with a redirect pending to show reset wins and discards it.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0444;
    inst_ready     = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    syscall_en     = 1'b0;
    q.delete();
    m_pc   = RESET_PC;
    m_halt = 1'b0;

    // Reset state and sequential fetch with ready held high.
    do_reset();
    check("reset_fetch_pc", fetch_pc, RESET_PC);
    check("reset_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    // Backpressure: FIFO fills to DEPTH, PC holds at 0x10, then drains in order.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0);
    check("bp_fetch_pc_hold", fetch_pc, 32'h0000_0010);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Full FIFO with a single-cycle ready: one pop and one push.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("full_pop_push_pc", fetch_pc, 32'h0000_0014);
    check("full_new_head", inst_pc, 32'h0000_0004);
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b0);

    // Mid-operation reset, then redirect with three entries held.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0203, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("redir_head_pc", inst_pc, 32'h0000_0200);
    check("redir_head_data", inst_data, 32'h1000_0080);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

    // ROM alias wrap at 4 KiB.
    cycle(1'b1, 32'h0000_0FFC, 1'b1);
    check("wrap_rom_addr_hi", {22'd0, rom_addr}, 32'h0000_03FF);
    cycle(1'b0, 32'h0, 1'b1);
    check("wrap_rom_addr_lo", {22'd0, rom_addr}, 32'h0000_0000);
    cycle(1'b0, 32'h0, 1'b1);
    check("wrap_head_pc", inst_pc, 32'h0000_1000);
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1);

    // 32-bit PC wrap.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("pc32_wrap_head", inst_pc, 32'h0000_0000);
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1);

    // SYSCALL at 0x8: halts with the macro, fetched normally without.
    syscall_en = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
`ifdef IF_HALT_DETECT_EN
    check("halt_set", {31'd0, halted}, 32'd1);
    check("halt_pc_frozen", fetch_pc, 32'h0000_000C);
`else
    check("no_halt", {31'd0, halted}, 32'd0);
`endif
    cycle(1'b1, 32'h0000_0040, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    syscall_en = 1'b0;

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      bit          rv;
      bit          rdy;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      if ($urandom_range(0, 29) == 0) syscall_en = ~syscall_en;
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        1:       tgt = 32'h0000_0FF0 | ($urandom & 32'hF);
        default: tgt = $urandom & 32'h0000_1FFF;
      endcase
      cycle(rv, tgt, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
